// File: rtl/reset_seq_ctrl.sv
// Staggered multi-channel reset sequencer: arbitrates root, debug-module and software requests.
// Optional sticky reset-cause register enabled by defining RESET_SEQ_CTRL_CAUSE_EN.
module reset_seq_ctrl #(
   parameter int                    N_CHANNELS     = 4,
   parameter int                    HOLD_CYCLES    = 4,
   parameter int                    STAGGER_CYCLES = 2,
   parameter logic [N_CHANNELS-1:0] HART_MASK      = {{(N_CHANNELS-1){1'b0}}, 1'b1}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sys_reset_req,
   input  logic                  hart_reset_req,
   input  logic [N_CHANNELS-1:0] chan_reset_req,
`ifdef RESET_SEQ_CTRL_CAUSE_EN
   input  logic                  cause_clr,
   output logic [2:0]            reset_cause,
`endif
   output logic [N_CHANNELS-1:0] chan_rst_n,
   output logic                  sys_reset_done,
   output logic                  hart_reset_done,
   output logic                  busy
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int IDX_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CHANNELS - 1);
   localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_RELEASE,
      ST_IDLE
   } state_e;

   state_e                  state_q, state_d;
   logic [N_CHANNELS-1:0]   target_q, target_d;
   logic [N_CHANNELS-1:0]   chan_q, chan_d;
   logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [STG_W-1:0]        stg_cnt_q, stg_cnt_d;
   logic                    sys_done_q, sys_done_d;
   logic                    hart_done_q, hart_done_d;
   logic                    busy_q, busy_d;
   logic [N_CHANNELS-1:0]   req_mask;
   logic                    slot_first;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      target_d   = target_q;
      chan_d     = chan_q;
      hold_cnt_d = hold_cnt_q;
      idx_d      = idx_q;
      stg_cnt_d  = stg_cnt_q;
      slot_first = (stg_cnt_q == '0);
      req_mask   = {N_CHANNELS{sys_reset_req}}
                 | (hart_reset_req ? HART_MASK : '0)
                 | chan_reset_req;

      // Any request wins over sequencing: assert the requested channels and restart the hold.
      if (req_mask != '0) begin
         target_d   = target_q | req_mask;
         chan_d     = chan_q & ~req_mask;
         hold_cnt_d = '0;
         state_d    = ST_HOLD;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_d = '0;
                  idx_d      = '0;
                  stg_cnt_d  = '0;
                  state_d    = ST_RELEASE;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (slot_first && target_q[idx_q]) begin
                  chan_d[idx_q]   = 1'b1;
                  target_d[idx_q] = 1'b0;
               end
               // Untargeted slots are skipped in a single cycle.
               if ((slot_first && !target_q[idx_q]) || (stg_cnt_q == STG_LAST)) begin
                  stg_cnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_IDLE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  stg_cnt_d = stg_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
            end
            default: begin
               state_d = ST_HOLD;
            end
         endcase
      end

      sys_done_d  = (&chan_d) & ~sys_reset_req;
      hart_done_d = (&(chan_d | ~HART_MASK)) & ~hart_reset_req;
      busy_d      = (state_d != ST_IDLE);
   end

   // NOTE: state registers use non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HOLD;
         target_q    <= '1;
         chan_q      <= '0;
         hold_cnt_q  <= '0;
         idx_q       <= '0;
         stg_cnt_q   <= '0;
         sys_done_q  <= 1'b0;
         hart_done_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         chan_q      <= chan_d;
         hold_cnt_q  <= hold_cnt_d;
         idx_q       <= idx_d;
         stg_cnt_q   <= stg_cnt_d;
         sys_done_q  <= sys_done_d;
         hart_done_q <= hart_done_d;
         busy_q      <= busy_d;
      end
   end

   assign chan_rst_n      = chan_q;
   assign sys_reset_done  = sys_done_q;
   assign hart_reset_done = hart_done_q;
   assign busy            = busy_q;

`ifdef RESET_SEQ_CTRL_CAUSE_EN
   logic [2:0] cause_q, cause_d;

   // Bits {chan, hart, sys}; a new request outranks a simultaneous clear.
   always_comb begin
      cause_d = (cause_q & ~{3{cause_clr}})
              | {|chan_reset_req, hart_reset_req, sys_reset_req};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause_q <= 3'b000;
      end else begin
         cause_q <= cause_d;
      end
   end

   assign reset_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl: per-cycle vector tables fed through a scoreboard queue.
// Cause-register checks are compiled only when RESET_SEQ_CTRL_CAUSE_EN is defined.
module tb_reset_seq_ctrl;

   localparam int N     = 4;
   localparam int HOLD  = 4;
   localparam int STG   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sys_req = 1'b0;
   logic       hart_req = 1'b0;
   logic [3:0] chan_req = 4'b0000;
   logic [3:0] chan_rst_n;
   logic       sys_done;
   logic       hart_done;
   logic       busy;
`ifdef RESET_SEQ_CTRL_CAUSE_EN
   logic       cause_clr = 1'b0;
   logic [2:0] reset_cause;
`endif

   reset_seq_ctrl #(
      .N_CHANNELS     (N),
      .HOLD_CYCLES    (HOLD),
      .STAGGER_CYCLES (STG),
      .HART_MASK      (4'b0001)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sys_reset_req   (sys_req),
      .hart_reset_req  (hart_req),
      .chan_reset_req  (chan_req),
`ifdef RESET_SEQ_CTRL_CAUSE_EN
      .cause_clr       (cause_clr),
      .reset_cause     (reset_cause),
`endif
      .chan_rst_n      (chan_rst_n),
      .sys_reset_done  (sys_done),
      .hart_reset_done (hart_done),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       sys;
      logic       hart;
      logic [3:0] chan;
      logic [3:0] e_chan;
      logic       e_sd;
      logic       e_hd;
      logic       e_busy;
   } vec_t;

   typedef struct packed {
      logic [3:0] chan;
      logic       sd;
      logic       hd;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic h, input logic [3:0] c,
                               input logic [3:0] ec, input logic sd, input logic hd,
                               input logic b);
      vec_t v;
      v.sys    = s;
      v.hart   = h;
      v.chan   = c;
      v.e_chan = ec;
      v.e_sd   = sd;
      v.e_hd   = hd;
      v.e_busy = b;
      return v;
   endfunction

   // Drive one cycle of requests, queue the expected post-edge outputs, compare after the edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      sys_req  = v.sys;
      hart_req = v.hart;
      chan_req = v.chan;
      e.chan   = v.e_chan;
      e.sd     = v.e_sd;
      e.hd     = v.e_hd;
      e.busy   = v.e_busy;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, "/chan_rst_n"}, 32'(chan_rst_n), 32'(e.chan));
      check({tag, "/sys_done"},   32'(sys_done),   32'(e.sd));
      check({tag, "/hart_done"},  32'(hart_done),  32'(e.hd));
      check({tag, "/busy"},       32'(busy),       32'(e.busy));
   endtask

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", tag, i + 1));
      tbl.delete();
   endtask

   // Root release: rst dropped just after edge 0; bit i rises at edge HOLD+1+i*STG.
   task automatic root_release(input string tag);
      for (int e = 1; e <= 13; e++) begin : edge_blk
         logic [3:0] ec;
         for (int i = 0; i < N; i++) ec[i] = (e >= HOLD + 1 + i * STG);
         apply(mk(1'b0, 1'b0, 4'b0000, ec, &ec, ec[0],
                  (e < HOLD + 1 + (N - 1) * STG + STG - 1)),
               $sformatf("%s@%0d", tag, e));
      end
   endtask

   task automatic check_in_reset(input string tag);
      check({tag, "/chan_rst_n"}, 32'(chan_rst_n), 32'(4'b0000));
      check({tag, "/sys_done"},   32'(sys_done),   32'(1'b0));
      check({tag, "/hart_done"},  32'(hart_done),  32'(1'b0));
      check({tag, "/busy"},       32'(busy),       32'(1'b1));
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      #12;
      check_in_reset("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      root_release("root");

      // hart request for 3 cycles from IDLE: only channel 0 cycles.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b1110, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1110, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0));
      run_tbl("hart");

      // sys request every other cycle keeps everything in hold; release after 4 quiet cycles.
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk((i < 5) && (i % 2 == 0), 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0));
      run_tbl("sys_pulse");

      // Software reset of channels 0-1; channel 2 requested during channel 1's slot.
      tbl.push_back(mk(1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1100, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1101, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1011, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0));
      run_tbl("chan_mid");

      // sys pulse, then async root reset once channels 0-1 are out of reset.
      tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1));
      run_tbl("pre_async");
      #1 rst = 1'b1;
      #1;
      check_in_reset("async_rst");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      root_release("replay");
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

`ifdef RESET_SEQ_CTRL_CAUSE_EN
      check("cause_after_rst", 32'(reset_cause), 32'(3'b000));
      @(negedge clk);
      sys_req = 1'b1;
      @(negedge clk);
      sys_req  = 1'b0;
      hart_req = 1'b1;
      @(negedge clk);
      hart_req = 1'b0;
      @(posedge clk);
      #1;
      check("cause_sys_hart", 32'(reset_cause), 32'(3'b011));
      @(negedge clk);
      cause_clr = 1'b1;
      chan_req  = 4'b0001;
      @(posedge clk);
      #1;
      check("cause_clr_vs_chan", 32'(reset_cause), 32'(3'b100));
      @(negedge clk);
      cause_clr = 1'b0;
      chan_req  = 4'b0000;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
